// File: rtl/cmd_sequencer.sv
// cmd_sequencer: queues up to DEPTH SD CMD-path commands (index + argument)
// and issues them one at a time over the new_command/strobe_in/ack_in
// handshake. Each result is returned on a valid/ready port. The result is
// either the captured response or a timeout flag from an optional
// programmable WAIT timeout.
//
// Ports:
//   clock, reset                          clock, synchronous active-high reset
//   push, push_index, push_argument       enqueue side (dropped while full)
//   full, empty                           queue occupancy flags
//   timeout_enable, timeout_limit         response timeout control
//   new_command, cmd_index, cmd_argument  command request to the CMD layer
//   strobe_in, cmd_in, ack_in             response handshake with the CMD layer
//   resp_valid, resp_ready                result handshake with the consumer
//   response, resp_index, time_out        result payload
//   busy                                  sequencer not idle
module cmd_sequencer #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned ARG_W  = 32,
  parameter int unsigned RESP_W = 128,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TO_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [IDX_W-1:0]  push_index,
  input  logic [ARG_W-1:0]  push_argument,
  output logic              full,
  output logic              empty,
  input  logic              timeout_enable,
  input  logic [TO_W-1:0]   timeout_limit,
  output logic              new_command,
  output logic [IDX_W-1:0]  cmd_index,
  output logic [ARG_W-1:0]  cmd_argument,
  input  logic              strobe_in,
  input  logic [RESP_W-1:0] cmd_in,
  output logic              ack_in,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] response,
  output logic [IDX_W-1:0]  resp_index,
  output logic              time_out,
  output logic              busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_REPORT
  } state_t;

  state_t state_q, state_d;

  logic [DEPTH-1:0][IDX_W-1:0] idx_mem_q, idx_mem_d;
  logic [DEPTH-1:0][ARG_W-1:0] arg_mem_q, arg_mem_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;

  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              new_command_q, new_command_d;
  logic [IDX_W-1:0]  cmd_index_q, cmd_index_d;
  logic [ARG_W-1:0]  cmd_argument_q, cmd_argument_d;
  logic              ack_in_q, ack_in_d;
  logic              resp_valid_q, resp_valid_d;
  logic [RESP_W-1:0] response_q, response_d;
  logic [IDX_W-1:0]  resp_index_q, resp_index_d;
  logic              time_out_q, time_out_d;

  logic q_full;
  logic q_empty;
  logic push_ok;
  logic pop;

  assign q_full  = (count_q == DEPTH_CNT);
  assign q_empty = (count_q == '0);
  assign push_ok = push && !q_full;

  // Sequencer FSM; pop is asserted only in IDLE when the queue has an entry.
  always_comb begin
    state_d        = state_q;
    to_cnt_d       = to_cnt_q;
    new_command_d  = new_command_q;
    cmd_index_d    = cmd_index_q;
    cmd_argument_d = cmd_argument_q;
    ack_in_d       = ack_in_q;
    resp_valid_d   = resp_valid_q;
    response_d     = response_q;
    resp_index_d   = resp_index_q;
    time_out_d     = time_out_q;
    pop            = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          pop            = 1'b1;
          cmd_index_d    = idx_mem_q[rd_ptr_q];
          cmd_argument_d = arg_mem_q[rd_ptr_q];
          to_cnt_d       = '0;
          new_command_d  = 1'b1;
          state_d        = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
        // strobe_in wins over a timeout in the same cycle.
        if (strobe_in) begin
          response_d    = cmd_in;
          resp_index_d  = cmd_index_q;
          time_out_d    = 1'b0;
          new_command_d = 1'b0;
          ack_in_d      = 1'b1;
          state_d       = ST_ACK;
        end else if (timeout_enable && (to_cnt_q == timeout_limit)) begin
          response_d    = '0;
          resp_index_d  = cmd_index_q;
          time_out_d    = 1'b1;
          new_command_d = 1'b0;
          resp_valid_d  = 1'b1;
          state_d       = ST_REPORT;
        end
      end

      ST_ACK: begin
        if (!strobe_in) begin
          ack_in_d     = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_REPORT;
        end
      end

      ST_REPORT: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Circular command queue; a simultaneous push and pop leaves count unchanged.
  always_comb begin
    idx_mem_d = idx_mem_q;
    arg_mem_d = arg_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (push_ok) begin
      idx_mem_d[wr_ptr_q] = push_index;
      arg_mem_d[wr_ptr_q] = push_argument;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_mem_q      <= '0;
      arg_mem_q      <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      to_cnt_q       <= '0;
      new_command_q  <= 1'b0;
      cmd_index_q    <= '0;
      cmd_argument_q <= '0;
      ack_in_q       <= 1'b0;
      resp_valid_q   <= 1'b0;
      response_q     <= '0;
      resp_index_q   <= '0;
      time_out_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_mem_q      <= idx_mem_d;
      arg_mem_q      <= arg_mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      to_cnt_q       <= to_cnt_d;
      new_command_q  <= new_command_d;
      cmd_index_q    <= cmd_index_d;
      cmd_argument_q <= cmd_argument_d;
      ack_in_q       <= ack_in_d;
      resp_valid_q   <= resp_valid_d;
      response_q     <= response_d;
      resp_index_q   <= resp_index_d;
      time_out_q     <= time_out_d;
    end
  end

  assign full         = q_full;
  assign empty        = q_empty;
  assign busy         = (state_q != ST_IDLE);
  assign new_command  = new_command_q;
  assign cmd_index    = cmd_index_q;
  assign cmd_argument = cmd_argument_q;
  assign ack_in       = ack_in_q;
  assign resp_valid   = resp_valid_q;
  assign response     = response_q;
  assign resp_index   = resp_index_q;
  assign time_out     = time_out_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed testbench for cmd_sequencer (default parameters, DEPTH = 4).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_cmd_sequencer;

  logic         clock;
  logic         reset;
  logic         push;
  logic [5:0]   push_index;
  logic [31:0]  push_argument;
  logic         full;
  logic         empty;
  logic         timeout_enable;
  logic [15:0]  timeout_limit;
  logic         new_command;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_argument;
  logic         strobe_in;
  logic [127:0] cmd_in;
  logic         ack_in;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] response;
  logic [5:0]   resp_index;
  logic         time_out;
  logic         busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  cmd_sequencer #(
    .IDX_W (6),
    .ARG_W (32),
    .RESP_W(128),
    .DEPTH (4),
    .TO_W  (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .push          (push),
    .push_index    (push_index),
    .push_argument (push_argument),
    .full          (full),
    .empty         (empty),
    .timeout_enable(timeout_enable),
    .timeout_limit (timeout_limit),
    .new_command   (new_command),
    .cmd_index     (cmd_index),
    .cmd_argument  (cmd_argument),
    .strobe_in     (strobe_in),
    .cmd_in        (cmd_in),
    .ack_in        (ack_in),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .response      (response),
    .resp_index    (resp_index),
    .time_out      (time_out),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_new_command", 128'(new_command), 128'(0));
    check("rst_ack_in", 128'(ack_in), 128'(0));
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_time_out", 128'(time_out), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_full", 128'(full), 128'(0));
    check("rst_empty", 128'(empty), 128'(1));
    check("rst_response", response, 128'(0));
    check("rst_resp_index", 128'(resp_index), 128'(0));
    check("rst_cmd_index", 128'(cmd_index), 128'(0));
    check("rst_cmd_argument", 128'(cmd_argument), 128'(0));
  endtask

  // Waits (bounded) for a command issue, then completes it with a one-cycle strobe.
  task automatic serve(input logic [5:0] idx, input logic [31:0] arg, input logic [127:0] r);
    int unsigned n;
    n = 0;
    while (new_command !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("issue", 128'(new_command), 128'(1));
    check("issue_index", 128'(cmd_index), 128'(idx));
    check("issue_argument", 128'(cmd_argument), 128'(arg));
    strobe_in = 1'b1;
    cmd_in    = r;
    tick();
    check("srv_ack_high", 128'(ack_in), 128'(1));
    check("srv_nc_low", 128'(new_command), 128'(0));
    strobe_in = 1'b0;
    tick();
    check("srv_ack_low", 128'(ack_in), 128'(0));
    check("srv_valid", 128'(resp_valid), 128'(1));
    check("srv_response", response, r);
    check("srv_resp_index", 128'(resp_index), 128'(idx));
    check("srv_time_out", 128'(time_out), 128'(0));
    resp_ready = 1'b1;
    tick();
    check("srv_valid_drop", 128'(resp_valid), 128'(0));
    resp_ready = 1'b0;
  endtask

  task automatic do_push(input logic [5:0] idx, input logic [31:0] arg);
    push          = 1'b1;
    push_index    = idx;
    push_argument = arg;
    tick();
    push = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    push           = 1'b0;
    push_index     = '0;
    push_argument  = '0;
    timeout_enable = 1'b0;
    timeout_limit  = '0;
    strobe_in      = 1'b0;
    cmd_in         = '0;
    resp_ready     = 1'b0;
    tick();
    tick();
    check_reset_state();
    reset = 1'b0;
    tick();

    // Single command, strobe held for three cycles.
    do_push(6'h18, 32'hFF99FF88);
    check("t1_empty_low", 128'(empty), 128'(0));
    check("t1_nc_not_yet", 128'(new_command), 128'(0));
    tick();
    check("t1_nc_high", 128'(new_command), 128'(1));
    check("t1_busy", 128'(busy), 128'(1));
    check("t1_cmd_index", 128'(cmd_index), 128'(6'h18));
    check("t1_cmd_arg", 128'(cmd_argument), 128'(32'hFF99FF88));
    strobe_in = 1'b1;
    cmd_in    = 128'hFFFF9999EEEE8888DDDD7777CCCC6666;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_ack_held", 128'(ack_in), 128'(1));
      check("t1_nc_dropped", 128'(new_command), 128'(0));
      check("t1_no_valid_yet", 128'(resp_valid), 128'(0));
    end
    strobe_in = 1'b0;
    tick();
    check("t1_ack_fall", 128'(ack_in), 128'(0));
    check("t1_valid", 128'(resp_valid), 128'(1));
    check("t1_response", response, 128'hFFFF9999EEEE8888DDDD7777CCCC6666);
    check("t1_resp_index", 128'(resp_index), 128'(6'h18));
    check("t1_time_out", 128'(time_out), 128'(0));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("t1_valid_drop", 128'(resp_valid), 128'(0));
    check("t1_idle", 128'(busy), 128'(0));

    // Timeout with limit 5: fires on the 6th WAIT edge.
    timeout_enable = 1'b1;
    timeout_limit  = 16'd5;
    do_push(6'h05, 32'h0000_0001);
    tick();
    check("t2_nc_high", 128'(new_command), 128'(1));
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t2_no_valid", 128'(resp_valid), 128'(0));
      check("t2_no_ack", 128'(ack_in), 128'(0));
      check("t2_nc_held", 128'(new_command), 128'(1));
    end
    tick();
    check("t2_valid", 128'(resp_valid), 128'(1));
    check("t2_time_out", 128'(time_out), 128'(1));
    check("t2_response_zero", response, 128'(0));
    check("t2_no_ack", 128'(ack_in), 128'(0));
    check("t2_nc_low", 128'(new_command), 128'(0));
    check("t2_resp_index", 128'(resp_index), 128'(6'h05));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("t2_valid_drop", 128'(resp_valid), 128'(0));
    timeout_enable = 1'b0;

    // Queue full: head stalled in WAIT, then five pushes back-to-back.
    do_push(6'h01, 32'hA000_0001);
    tick();
    check("t3_stalled", 128'(new_command), 128'(1));
    push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_index    = 6'(6'h02 + i);
      push_argument = 32'hB000_0000 + 32'(i);
      tick();
      check("t3_full", 128'(full), 128'(i >= 3));
      check("t3_not_empty", 128'(empty), 128'(0));
    end
    push = 1'b0;
    serve(6'h01, 32'hA000_0001, 128'h1111);
    for (int i = 0; i < 4; i++) begin
      serve(6'(6'h02 + i), 32'hB000_0000 + 32'(i), 128'h2000 + 128'(i));
    end
    tick();
    tick();
    tick();
    check("t3_drained_empty", 128'(empty), 128'(1));
    check("t3_drained_idle", 128'(busy), 128'(0));
    check("t3_no_extra_cmd", 128'(new_command), 128'(0));

    // Backpressure: result held for 10 cycles with another command queued.
    do_push(6'h0A, 32'hC0DE_000A);
    do_push(6'h0B, 32'hC0DE_000B);
    check("t4_issue", 128'(new_command), 128'(1));
    strobe_in = 1'b1;
    cmd_in    = 128'hABCD_0000_1234_5678_9ABC_DEF0_0F0F_F0F0;
    tick();
    strobe_in = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_valid_held", 128'(resp_valid), 128'(1));
      check("t4_response_held", response, 128'hABCD_0000_1234_5678_9ABC_DEF0_0F0F_F0F0);
      check("t4_nc_low", 128'(new_command), 128'(0));
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("t4_valid_drop", 128'(resp_valid), 128'(0));
    check("t4_nc_not_yet", 128'(new_command), 128'(0));
    tick();
    check("t4_next_issue", 128'(new_command), 128'(1));
    check("t4_next_index", 128'(cmd_index), 128'(6'h0B));
    serve(6'h0B, 32'hC0DE_000B, 128'h5555);

    // Priority: limit 0 with strobe in the first WAIT cycle.
    timeout_enable = 1'b1;
    timeout_limit  = 16'd0;
    do_push(6'h15, 32'h0000_0015);
    serve(6'h15, 32'h0000_0015, 128'h7777_8888);
    timeout_enable = 1'b0;

    // Reset while in ACK with two commands queued.
    do_push(6'h21, 32'h0000_0021);
    do_push(6'h22, 32'h0000_0022);
    do_push(6'h23, 32'h0000_0023);
    strobe_in = 1'b1;
    cmd_in    = 128'hDEAD;
    tick();
    check("t6_in_ack", 128'(ack_in), 128'(1));
    check("t6_queued", 128'(empty), 128'(0));
    reset     = 1'b1;
    strobe_in = 1'b0;
    tick();
    check_reset_state();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_no_result", 128'(resp_valid), 128'(0));
      check("t6_no_issue", 128'(new_command), 128'(0));
      check("t6_still_empty", 128'(empty), 128'(1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
